// File: rtl/dt_gen2.sv
// Two-pass chamfer distance transform over a binary image held in a source ROM.
// The forward raster pass writes partial distances; the reverse pass refines them in place.
module dt_gen2 #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int WORD_W = 16,
   parameter int DIST_W = 8,
   localparam int AW  = $clog2(IMG_W * IMG_H),
   localparam int SAW = $clog2(IMG_W * IMG_H / WORD_W)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              metric_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              sti_rd_o,
   output logic [SAW-1:0]    sti_addr_o,
   input  logic [WORD_W-1:0] sti_di_i,
   output logic              res_wr_o,
   output logic              res_rd_o,
   output logic [AW-1:0]     res_addr_o,
   output logic [DIST_W-1:0] res_do_o,
   input  logic [DIST_W-1:0] res_di_i
);

   localparam int CW  = $clog2(IMG_W);
   localparam int WBW = $clog2(WORD_W);
   localparam logic [AW-1:0]     LAST_PIX = AW'(IMG_W * IMG_H - 1);
   localparam logic [DIST_W-1:0] DMAX     = '1;

   typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_e;

   state_e            state_q;
   logic [AW-1:0]     pix_q;
   logic              metric_q;
   logic              busy_q;
   logic              done_q;
   logic [DIST_W-1:0] lb_q [IMG_W+1];

   function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
      return (v == DMAX) ? v : v + DIST_W'(1);
   endfunction

   function automatic logic [DIST_W-1:0] dmin(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   logic [CW-1:0]    col;
   logic [AW-CW-1:0] row;
   logic [WBW-1:0]   bit_idx;
   logic             first_col, last_col, first_row, last_row;
   logic             fg, active;
   logic             adj_ok, vert_ok, diag_a_ok, diag_b_ok;
   logic [DIST_W-1:0] n_adj, n_vert, n_da, n_db, nb_min;
   logic [DIST_W-1:0] fwd_val, bwd_val, dist_val;

   assign col       = pix_q[CW-1:0];
   assign row       = pix_q[AW-1:CW];
   assign first_col = (col == '0);
   assign last_col  = &col;
   assign first_row = (row == '0);
   assign last_row  = &row;
   assign active    = (state_q == FWD) || (state_q == BWD);

   // Bit WORD_W-1 of the source word is the leftmost pixel, so the select is the inverted column offset.
   assign bit_idx = ~pix_q[WBW-1:0];
   assign fg      = sti_di_i[bit_idx];

   // Shift-register taps: [0] is the previous pixel, [IMG_W-1] the same column one row away,
   // [IMG_W] and [IMG_W-2] the two diagonals. Their meaning mirrors between the passes.
   assign adj_ok    = (state_q == BWD) ? !last_col : !first_col;
   assign vert_ok   = (state_q == BWD) ? !last_row : !first_row;
   assign diag_a_ok = vert_ok && ((state_q == BWD) ? !last_col  : !first_col);
   assign diag_b_ok = vert_ok && ((state_q == BWD) ? !first_col : !last_col);

   assign n_adj  = adj_ok    ? lb_q[0]       : '0;
   assign n_vert = vert_ok   ? lb_q[IMG_W-1] : '0;
   assign n_da   = diag_a_ok ? lb_q[IMG_W]   : '0;
   assign n_db   = diag_b_ok ? lb_q[IMG_W-2] : '0;

   assign nb_min   = metric_q ? dmin(n_adj, n_vert)
                              : dmin(dmin(n_adj, n_vert), dmin(n_da, n_db));
   assign fwd_val  = fg ? sat_inc(nb_min) : '0;
   assign bwd_val  = (res_di_i == '0) ? '0 : dmin(res_di_i, sat_inc(nb_min));
   assign dist_val = (state_q == FWD) ? fwd_val : bwd_val;

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign sti_rd_o   = (state_q == FWD);
   assign sti_addr_o = (state_q == FWD) ? pix_q[AW-1:WBW] : '0;
   assign res_wr_o   = active;
   assign res_rd_o   = (state_q == BWD);
   assign res_addr_o = pix_q;
   assign res_do_o   = active ? dist_val : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         pix_q    <= '0;
         metric_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               state_q  <= FWD;
               busy_q   <= 1'b1;
               metric_q <= metric_i;
               pix_q    <= '0;
            end
            FWD: begin
               if (pix_q == LAST_PIX) state_q <= BWD;
               else                   pix_q   <= pix_q + AW'(1);
            end
            BWD: begin
               if (pix_q == '0) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  pix_q <= pix_q - AW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: the line buffer has no reset; every tap is masked until this pass has refilled it,
   // so stale contents after an abort are never observed and the array maps to plain storage.
   always_ff @(posedge clk_i) begin
      if (active) begin
         for (int i = IMG_W; i > 0; i--) lb_q[i] <= lb_q[i-1];
         lb_q[0] <= dist_val;
      end
   end

endmodule

// File: tb/tb_dt_gen2.sv
// Scoreboard bench for dt_gen2 on a 16x16 image; a second instance with DIST_W=3 covers saturation.
module tb_dt_gen2;

   localparam int W = 16, H = 16, N = W * H;

   logic clk = 1'b0;
   logic rst_n, start, metric;

   logic       busy8, done8, sti_rd8, res_wr8, res_rd8;
   logic [3:0] sti_addr8;
   logic [15:0] sti_di8;
   logic [7:0] res_addr8, res_do8, res_di8;

   logic       busy3, done3, sti_rd3, res_wr3, res_rd3;
   logic [3:0] sti_addr3;
   logic [15:0] sti_di3;
   logic [7:0] res_addr3;
   logic [2:0] res_do3, res_di3;

   logic [N-1:0] img_rev;
   logic [7:0]   ram8 [N];
   logic [2:0]   ram3 [N];

   typedef struct { int addr; int val; bit bwd; } exp_t;
   exp_t sbq [$];
   exp_t sb_e;

   int n_checks = 0, n_fail = 0;
   int pos_cnt = 0, start_pos = 0, nwr = 0, done_cnt = 0;
   int mf [N], mb [N], exp3 [N];

   dt_gen2 #(.IMG_W(W), .IMG_H(H), .WORD_W(16), .DIST_W(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .metric_i(metric),
      .busy_o(busy8), .done_o(done8), .sti_rd_o(sti_rd8), .sti_addr_o(sti_addr8),
      .sti_di_i(sti_di8), .res_wr_o(res_wr8), .res_rd_o(res_rd8),
      .res_addr_o(res_addr8), .res_do_o(res_do8), .res_di_i(res_di8));

   dt_gen2 #(.IMG_W(W), .IMG_H(H), .WORD_W(16), .DIST_W(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .metric_i(metric),
      .busy_o(busy3), .done_o(done3), .sti_rd_o(sti_rd3), .sti_addr_o(sti_addr3),
      .sti_di_i(sti_di3), .res_wr_o(res_wr3), .res_rd_o(res_rd3),
      .res_addr_o(res_addr3), .res_do_o(res_do3), .res_di_i(res_di3));

   always #5 clk = ~clk;
   always @(posedge clk) pos_cnt++;

   // Pixel p is stored at img_rev[N-1-p], so a descending slice yields leftmost-pixel-in-MSB words.
   always_comb begin
      sti_di8 = img_rev[(N-1) - 16*int'(sti_addr8) -: 16];
      sti_di3 = img_rev[(N-1) - 16*int'(sti_addr3) -: 16];
      res_di8 = ram8[res_addr8];
      res_di3 = ram3[res_addr3];
   end

   always @(posedge clk) begin
      if (res_wr8) ram8[res_addr8] <= res_do8;
      if (res_wr3) ram3[res_addr3] <= res_do3;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done8) done_cnt++;
      if (rst_n && res_wr8) begin
         nwr++;
         if (sbq.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            sb_e = sbq.pop_front();
            check($sformatf("wr_addr p%0d", sb_e.addr), res_addr8, sb_e.addr);
            check($sformatf("wr_data p%0d bwd%0d", sb_e.addr, sb_e.bwd), res_do8, sb_e.val);
            check($sformatf("res_rd p%0d", sb_e.addr), res_rd8, sb_e.bwd);
            check($sformatf("sti_rd p%0d", sb_e.addr), sti_rd8, !sb_e.bwd);
            if (!sb_e.bwd) check($sformatf("sti_addr p%0d", sb_e.addr), sti_addr8, sb_e.addr / 16);
         end
      end
   end

   // ---------------- reference model: plain 2-D two-pass chamfer ----------------
   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int pix(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return int'(img_rev[N-1-(r*W+c)]);
   endfunction

   function automatic int fv(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return mf[r*W+c];
   endfunction

   function automatic int bv(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return mb[r*W+c];
   endfunction

   task automatic model(input bit m, input int maxv);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            int mn;
            if (pix(r, c) == 0) mf[r*W+c] = 0;
            else begin
               mn = imin(fv(r, c-1), fv(r-1, c));
               if (!m) mn = imin(mn, imin(fv(r-1, c-1), fv(r-1, c+1)));
               mf[r*W+c] = imin(mn + 1, maxv);
            end
         end
      for (int r = H-1; r >= 0; r--)
         for (int c = W-1; c >= 0; c--) begin
            int mn;
            if (mf[r*W+c] == 0) mb[r*W+c] = 0;
            else begin
               mn = imin(bv(r, c+1), bv(r+1, c));
               if (!m) mn = imin(mn, imin(bv(r+1, c-1), bv(r+1, c+1)));
               mb[r*W+c] = imin(mf[r*W+c], imin(mn + 1, maxv));
            end
         end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_px(input int r, input int c, input logic v);
      img_rev[N-1-(r*W+c)] = v;
   endtask

   task automatic launch(input bit m);
      model(m, 7);
      for (int p = 0; p < N; p++) exp3[p] = mb[p];
      model(m, 255);
      for (int p = 0; p < N; p++) sbq.push_back('{addr: p, val: mf[p], bwd: 1'b0});
      for (int p = N-1; p >= 0; p--) sbq.push_back('{addr: p, val: mb[p], bwd: 1'b1});
      nwr = 0;
      @(negedge clk);
      start  = 1'b1;
      metric = m;
      @(posedge clk);
      #1;
      start     = 1'b0;
      start_pos = pos_cnt;
      @(negedge clk);
      check("busy_first_cycle", busy8, 1);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      int nbad = 0;
      for (int i = 0; i < 3*N; i++) begin
         @(negedge clk);
         if (done8) begin seen = 1'b1; break; end
      end
      check("done_seen", seen, 1);
      check("done_latency", pos_cnt - start_pos + 1, 2*N + 1);
      check("busy_in_done", busy8, 0);
      check("done3_in_step", done3, 1);
      check("write_count", nwr, 2*N);
      check("sb_drained", sbq.size(), 0);
      for (int p = 0; p < N; p++) if (ram3[p] !== 3'(exp3[p])) nbad++;
      check("dut3_results", nbad, 0);
      @(negedge clk);
      check("done_one_cycle", done8, 0);
      check("busy_after_done", busy8, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, busy8, 0);
      check({tag, "_done"}, done8, 0);
      check({tag, "_sti_rd"}, sti_rd8, 0);
      check({tag, "_res_rd"}, res_rd8, 0);
      check({tag, "_res_wr"}, res_wr8, 0);
      check({tag, "_sti_addr"}, sti_addr8, 0);
      check({tag, "_res_addr"}, res_addr8, 0);
      check({tag, "_res_do"}, res_do8, 0);
   endtask

   task automatic load_single();
      img_rev = '0;
      set_px(5, 5, 1'b1);
   endtask

   task automatic check_single();
      int n = 0;
      check("single_center", ram8[5*W+5], 1);
      for (int p = 0; p < N; p++) if (p != 5*W+5 && ram8[p] != 0) n++;
      check("single_others_zero", n, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0;
      bit found;
      rst_n = 1'b0; start = 1'b0; metric = 1'b0; img_rev = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;

      // All background: every write is zero.
      launch(1'b0);
      wait_done();

      // One foreground pixel.
      load_single();
      launch(1'b0);
      wait_done();
      check_single();

      // All foreground with one hole at (8,8), both metrics.
      img_rev = '1;
      set_px(8, 8, 1'b0);
      launch(1'b0);
      wait_done();
      check("hole_chess_9_9", ram8[9*W+9], 1);
      check("hole_chess_0_0", ram8[0], 1);
      launch(1'b1);
      wait_done();
      check("hole_city_9_9", ram8[9*W+9], 2);
      check("hole_city_0_0", ram8[0], 1);

      // All foreground: border distance only; the 3-bit instance saturates.
      img_rev = '1;
      launch(1'b0);
      wait_done();
      check("full8_8_8", ram8[8*W+8], 8);
      check("full3_8_8_sat", ram3[8*W+8], 7);
      check("full3_0_7", ram3[7], 1);
      n = 0;
      for (int p = 0; p < N; p++) if (ram3[p] == 0) n++;
      check("full3_no_wrap", n, 0);

      // Dense random images under both metrics.
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < N; p++) img_rev[p] = ($urandom_range(0, 5) != 0);
         launch(k[0]);
         wait_done();
      end

      // Abort at pixel 100 of the forward pass, then rerun cleanly.
      img_rev = '1;
      launch(1'b0);
      found = 1'b0;
      for (int i = 0; i < 2*N; i++) begin
         if (res_wr8 && sti_rd8 && res_addr8 == 8'd100) begin found = 1'b1; break; end
         @(negedge clk);
      end
      check("abort_reached_p100", found, 1);
      #1 rst_n = 1'b0;
      #1 check_idle("abort_now");
      sbq.delete();
      @(negedge clk);
      check_idle("abort_next");
      rst_n = 1'b1;
      load_single();
      launch(1'b0);
      wait_done();
      check_single();

      // Start and metric toggled during the backward pass must be ignored.
      img_rev = '1;
      set_px(8, 8, 1'b0);
      d0 = done_cnt;
      launch(1'b0);
      found = 1'b0;
      for (int i = 0; i < 2*N; i++) begin
         @(negedge clk);
         if (res_rd8) begin found = 1'b1; break; end
      end
      check("bwd_reached", found, 1);
      start  = 1'b1;
      metric = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (6) @(negedge clk);
      check("single_done_pulse", done_cnt - d0, 1);
      check("no_restart_busy", busy8, 0);
      check("latched_chess_9_9", ram8[9*W+9], 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
